// File: rtl/husky_adc_spi_responder_if.sv
// Serial register-port lines between the Husky host (master) and the ADC
// register port (slave): SEN/SCLK/SDATA toward the ADC, OVR/SDOUT back.
interface husky_adc_spi_responder_if;
  logic adc_sen;
  logic adc_sclk;
  logic adc_sdata;
  logic adc_ovr_sdout;

  modport master (
    output adc_sen,
    output adc_sclk,
    output adc_sdata,
    input  adc_ovr_sdout
  );

  modport slave (
    input  adc_sen,
    input  adc_sclk,
    input  adc_sdata,
    output adc_ovr_sdout
  );
endinterface

// File: rtl/husky_adc_spi_responder.sv
// ADS4128-style serial register port emulator: decodes 16-bit SEN/SCLK/SDATA
// frames into a local register file and serves serial readout on OVR/SDOUT.
module husky_adc_spi_responder #(
  parameter int pNUM_REGS    = 32,
  parameter int pSYNC_STAGES = 2
) (
  input  logic                           clk_usb,
  input  logic                           reset_n,
  husky_adc_spi_responder_if.slave       spi,
  input  logic                           ovr_i,
  output logic                           readout_en,
  output logic                           wr_strobe,
  output logic [7:0]                     wr_addr,
  output logic [7:0]                     wr_data,
  output logic                           frame_error,
  input  logic [7:0]                     dbg_addr,
  output logic [7:0]                     dbg_data
);

  localparam int AW = (pNUM_REGS > 1) ? $clog2(pNUM_REGS) : 1;

  logic [pSYNC_STAGES-1:0] sen_sync_q, sclk_sync_q, sdata_sync_q;
  logic                    sen_prev_q, sclk_prev_q;
  logic                    sen_s, sclk_s, sdata_s;
  logic                    sen_fall, sen_rise, sclk_fall, capture;

  logic [4:0]  cnt_q, cnt_d, base_cnt;
  logic [15:0] shift_q, shift_d, base_shift;
  logic [7:0]  rd_sr_q, rd_sr_d, base_rd;

  logic [7:0]  regs_q [pNUM_REGS];
  logic        commit_valid, commit_write, frame_err_d, soft_rst_d;
  logic [7:0]  commit_addr, commit_data;

  logic        wr_strobe_q, frame_error_q, soft_rst_q;
  logic [7:0]  wr_addr_q, wr_data_q;

  // Idle levels on reset (SEN/SCLK high) so releasing reset never fakes an edge.
  always_ff @(posedge clk_usb or negedge reset_n) begin
    if (!reset_n) begin
      sen_sync_q   <= '1;
      sclk_sync_q  <= '1;
      sdata_sync_q <= '0;
      sen_prev_q   <= 1'b1;
      sclk_prev_q  <= 1'b1;
    end else begin
      sen_sync_q   <= {sen_sync_q[pSYNC_STAGES-2:0], spi.adc_sen};
      sclk_sync_q  <= {sclk_sync_q[pSYNC_STAGES-2:0], spi.adc_sclk};
      sdata_sync_q <= {sdata_sync_q[pSYNC_STAGES-2:0], spi.adc_sdata};
      sen_prev_q   <= sen_s;
      sclk_prev_q  <= sclk_s;
    end
  end

  assign sen_s     = sen_sync_q[pSYNC_STAGES-1];
  assign sclk_s    = sclk_sync_q[pSYNC_STAGES-1];
  assign sdata_s   = sdata_sync_q[pSYNC_STAGES-1];
  assign sen_fall  = sen_prev_q & ~sen_s;
  assign sen_rise  = ~sen_prev_q & sen_s;
  assign sclk_fall = sclk_prev_q & ~sclk_s;
  // A fall coinciding with the SEN rise still belongs to the ending frame.
  assign capture   = sclk_fall & (~sen_s | sen_rise);

  function automatic logic [7:0] reg_rd(input logic [7:0] a);
    if (int'(a) < pNUM_REGS) reg_rd = regs_q[a[AW-1:0]];
    else                     reg_rd = 8'h00;
  endfunction

  always_comb begin
    base_cnt   = sen_fall ? 5'd0  : cnt_q;
    base_shift = sen_fall ? 16'd0 : shift_q;
    base_rd    = sen_fall ? 8'd0  : rd_sr_q;
    cnt_d      = base_cnt;
    shift_d    = base_shift;
    rd_sr_d    = base_rd;
    if (capture) begin
      shift_d = {base_shift[14:0], sdata_s};
      cnt_d   = (base_cnt == 5'd17) ? 5'd17 : base_cnt + 5'd1;
      if (readout_en && cnt_d == 5'd8) rd_sr_d = reg_rd(shift_d[7:0]);
      else                             rd_sr_d = {base_rd[6:0], 1'b0};
    end
    commit_valid = sen_rise && (cnt_d == 5'd16);
    commit_addr  = shift_d[15:8];
    commit_data  = shift_d[7:0];
    // With readout enabled, frames to any address but 0x00 are reads.
    commit_write = commit_valid && (!readout_en || commit_addr == 8'h00);
    soft_rst_d   = commit_write && (commit_addr == 8'h00) && commit_data[1];
    frame_err_d  = sen_rise && (cnt_d != 5'd16) && (cnt_d != 5'd0);
    if (sen_rise) begin
      cnt_d   = 5'd0;
      rd_sr_d = 8'd0;
    end
  end

  always_ff @(posedge clk_usb or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q         <= '0;
      shift_q       <= '0;
      rd_sr_q       <= '0;
      wr_strobe_q   <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      frame_error_q <= 1'b0;
      soft_rst_q    <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      shift_q       <= shift_d;
      rd_sr_q       <= rd_sr_d;
      wr_strobe_q   <= commit_write;
      frame_error_q <= frame_err_d;
      soft_rst_q    <= soft_rst_d;
      if (commit_write) begin
        wr_addr_q <= commit_addr;
        wr_data_q <= commit_data;
      end
    end
  end

  // RESET bit is self-clearing: never stored, it only schedules the wipe.
  always_ff @(posedge clk_usb or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < pNUM_REGS; i++) regs_q[i] <= 8'h00;
    end else if (soft_rst_q) begin
      for (int i = 0; i < pNUM_REGS; i++) regs_q[i] <= 8'h00;
    end else if (commit_write && int'(commit_addr) < pNUM_REGS) begin
      regs_q[commit_addr[AW-1:0]] <= (commit_addr == 8'h00) ? (commit_data & 8'hFD)
                                                            : commit_data;
    end
  end

  assign readout_en        = regs_q[0][0];
  assign wr_strobe         = wr_strobe_q;
  assign wr_addr           = wr_addr_q;
  assign wr_data           = wr_data_q;
  assign frame_error       = frame_error_q;
  assign dbg_data          = reg_rd(dbg_addr);
  assign spi.adc_ovr_sdout = (readout_en && !sen_s) ? rd_sr_q[7] : ovr_i;

endmodule

// File: tb/tb_husky_adc_spi_responder.sv
// Directed bench for husky_adc_spi_responder: bit-bangs host frames at
// 1 us per SCLK level and checks writes, readout, errors and resets.
module tb_husky_adc_spi_responder;

  localparam int LVL = 100;  // clk_usb cycles per serial level (10 ns clock)

  logic       clk_usb;
  logic       reset_n;
  logic       ovr_i;
  logic       readout_en;
  logic       wr_strobe;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       frame_error;
  logic [7:0] dbg_addr;
  logic [7:0] dbg_data;

  husky_adc_spi_responder_if spi_if ();

  husky_adc_spi_responder #(.pNUM_REGS(32), .pSYNC_STAGES(2)) dut (
    .clk_usb     (clk_usb),
    .reset_n     (reset_n),
    .spi         (spi_if.slave),
    .ovr_i       (ovr_i),
    .readout_en  (readout_en),
    .wr_strobe   (wr_strobe),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .frame_error (frame_error),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  // ---------------- clock / reset ----------------
  initial clk_usb = 1'b0;
  always #5 clk_usb = ~clk_usb;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int strobe_cnt = 0;
  int err_cnt    = 0;
  logic       prev_strobe = 1'b0;
  logic [7:0] dbg_at_strobe = 8'h00;
  logic [7:0] dbg_after_strobe = 8'h00;
  logic       ro_at_strobe = 1'b0;
  logic       ro_after_strobe = 1'b0;

  always @(negedge clk_usb) begin
    if (wr_strobe) begin
      strobe_cnt++;
      dbg_at_strobe = dbg_data;
      ro_at_strobe  = readout_en;
    end
    if (prev_strobe) begin
      dbg_after_strobe = dbg_data;
      ro_after_strobe  = readout_en;
    end
    if (frame_error) err_cnt++;
    prev_strobe = wr_strobe;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_usb);
  endtask

  // Sends nbits MSB-first; collects SDOUT just before falling edges 9..16.
  // abort_at > 0 pulses reset_n after that many bits instead of finishing.
  task automatic send_frame(input int nbits, input logic [31:0] bits,
                            input int abort_at, output logic [7:0] rd_byte);
    rd_byte = 8'h00;
    spi_if.adc_sen = 1'b0;
    wait_cyc(LVL);
    for (int i = 0; i < nbits; i++) begin
      if (abort_at != 0 && i == abort_at) begin
        reset_n = 1'b0;
        spi_if.adc_sen  = 1'b1;
        spi_if.adc_sclk = 1'b1;
        wait_cyc(20);
        reset_n = 1'b1;
        wait_cyc(20);
        return;
      end
      spi_if.adc_sdata = bits[nbits-1-i];
      spi_if.adc_sclk  = 1'b1;
      wait_cyc(LVL);
      if (i >= 8 && i < 16) rd_byte = {rd_byte[6:0], spi_if.adc_ovr_sdout};
      spi_if.adc_sclk = 1'b0;
      wait_cyc(LVL);
    end
    spi_if.adc_sclk = 1'b1;
    wait_cyc(LVL);
    spi_if.adc_sen = 1'b1;
    wait_cyc(LVL);
  endtask

  task automatic write_reg(input logic [7:0] a, input logic [7:0] d);
    logic [7:0] unused_rd;
    send_frame(16, {16'h0, a, d}, 0, unused_rd);
  endtask

  task automatic peek(input logic [7:0] a, output logic [7:0] d);
    dbg_addr = a;
    wait_cyc(1);
    d = dbg_data;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] rd;
    logic [7:0] pk;
    int s0;
    int e0;

    reset_n          = 1'b0;
    ovr_i            = 1'b1;
    dbg_addr         = 8'h00;
    spi_if.adc_sen   = 1'b1;
    spi_if.adc_sclk  = 1'b1;
    spi_if.adc_sdata = 1'b0;
    wait_cyc(10);
    reset_n = 1'b1;
    wait_cyc(10);

    // Reset state
    check_eq("rst_readout_en", readout_en, 0);
    check_eq("rst_wr_strobe", wr_strobe, 0);
    check_eq("rst_wr_addr", wr_addr, 8'h00);
    check_eq("rst_wr_data", wr_data, 8'h00);
    check_eq("rst_frame_error", frame_error, 0);
    peek(8'h00, pk);
    check_eq("rst_reg00", pk, 8'h00);
    check_eq("rst_sdout_ovr", spi_if.adc_ovr_sdout, 1);

    // Plain write to 0x55 (beyond 32 regs: strobe but no storage)
    s0 = strobe_cnt; e0 = err_cnt;
    write_reg(8'h55, 8'hAA);
    check_eq("w55_strobes", strobe_cnt - s0, 1);
    check_eq("w55_errors", err_cnt - e0, 0);
    check_eq("w55_wr_addr", wr_addr, 8'h55);
    check_eq("w55_wr_data", wr_data, 8'hAA);
    peek(8'h55, pk);
    check_eq("w55_dbg", pk, 8'h00);

    // Readout of 0x05
    write_reg(8'h05, 8'h3C);
    peek(8'h05, pk);
    check_eq("w05_dbg", pk, 8'h3C);
    write_reg(8'h00, 8'h01);
    check_eq("ro_enabled", readout_en, 1);
    ovr_i = 1'b0;
    wait_cyc(2);
    check_eq("ro_sen_high_ovr0", spi_if.adc_ovr_sdout, 0);
    ovr_i = 1'b1;
    wait_cyc(2);
    check_eq("ro_sen_high_ovr1", spi_if.adc_ovr_sdout, 1);
    s0 = strobe_cnt;
    send_frame(16, 32'h0000_0500, 0, rd);
    check_eq("ro_read05_bits", rd, 8'h3C);
    check_eq("ro_read05_strobes", strobe_cnt - s0, 0);
    peek(8'h05, pk);
    check_eq("ro_read05_unchanged", pk, 8'h3C);

    // Unimplemented address with readout on, then a write with readout off
    send_frame(16, 32'h0000_4000, 0, rd);
    check_eq("ro_read40_bits", rd, 8'h00);
    write_reg(8'h00, 8'h00);
    check_eq("ro_disabled", readout_en, 0);
    s0 = strobe_cnt;
    write_reg(8'h40, 8'h99);
    check_eq("w40_strobes", strobe_cnt - s0, 1);
    check_eq("w40_wr_addr", wr_addr, 8'h40);
    check_eq("w40_wr_data", wr_data, 8'h99);
    peek(8'h40, pk);
    check_eq("w40_dbg", pk, 8'h00);
    peek(8'h05, pk);
    check_eq("w40_reg05_kept", pk, 8'h3C);

    // Short (12-bit) and long (20-bit) frames
    s0 = strobe_cnt; e0 = err_cnt;
    send_frame(12, 32'h0000_0A5F, 0, rd);
    check_eq("short_errors", err_cnt - e0, 1);
    send_frame(20, 32'h0005_1234, 0, rd);
    check_eq("long_errors", err_cnt - e0, 2);
    check_eq("bad_frames_strobes", strobe_cnt - s0, 0);
    peek(8'h05, pk);
    check_eq("bad_frames_reg05", pk, 8'h3C);
    check_eq("bad_frames_wr_addr", wr_addr, 8'h40);

    // Soft reset through register 0x00 bit 1
    write_reg(8'h01, 8'h11);
    write_reg(8'h1F, 8'hFF);
    peek(8'h1F, pk);
    check_eq("pre_reg1f", pk, 8'hFF);
    write_reg(8'h00, 8'h01);
    dbg_addr = 8'h01;
    write_reg(8'h00, 8'h03);
    check_eq("srst_reg01_at_strobe", dbg_at_strobe, 8'h11);
    check_eq("srst_ro_at_strobe", ro_at_strobe, 1);
    check_eq("srst_reg01_after", dbg_after_strobe, 8'h00);
    check_eq("srst_ro_after", ro_after_strobe, 0);
    peek(8'h1F, pk);
    check_eq("srst_reg1f", pk, 8'h00);
    peek(8'h05, pk);
    check_eq("srst_reg05", pk, 8'h00);
    peek(8'h00, pk);
    check_eq("srst_reg00", pk, 8'h00);

    // Async reset mid-frame, then a clean frame
    s0 = strobe_cnt; e0 = err_cnt;
    send_frame(16, 32'h0000_0211, 9, rd);
    check_eq("arst_wr_addr_cleared", wr_addr, 8'h00);
    write_reg(8'h02, 8'h7E);
    check_eq("arst_strobes", strobe_cnt - s0, 1);
    check_eq("arst_errors", err_cnt - e0, 0);
    check_eq("arst_wr_addr", wr_addr, 8'h02);
    peek(8'h02, pk);
    check_eq("arst_reg02", pk, 8'h7E);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
